// File: rtl/ahb_arb_pkg.sv
// Shared state encodings, default burst length and sizing helper for the AHB request arbiter.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ISSUE  = 2'b01,
    S_ACTIVE = 2'b10,
    S_DONE   = 2'b11
  } arb_state_t;

  localparam int DEFAULT_BEATS = 4;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ahb_req_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr wins.
// Output is a one-hot grant plus its binary index; all-zero grant when nothing requests.
module rr_picker
  import ahb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);

  always_comb begin
    int          cand_i;
    logic [IW-1:0] cand;
    logic        found;
    gnt    = '0;
    idx    = '0;
    found  = 1'b0;
    cand_i = 0;
    cand   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand_i = int'(ptr) + off;
      if (cand_i >= NUM_REQ) cand_i = cand_i - NUM_REQ;
      cand = IW'(cand_i);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/ahb_req_arbiter.sv
// Round-robin arbiter multiplexing NUM_REQ requesters onto one AHB master port.
// Master request issues 1 cycle after a request is sampled in IDLE; beats are forwarded combinationally.
module ahb_req_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BEATS      = DEFAULT_BEATS
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_REQ-1:0]            i_rq_valid,
  input  logic [NUM_REQ-1:0]            i_rq_read,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_rq_addr,
  input  logic [NUM_REQ-1:0]            i_rq_wdata_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_rq_wdata,
  output logic [NUM_REQ-1:0]            o_rq_gnt,
  output logic [NUM_REQ-1:0]            o_rq_rdata_valid,
  output logic [DATA_WIDTH-1:0]         o_rq_rdata,
  output logic [NUM_REQ-1:0]            o_rq_done,
  output logic                          o_rq_err,
  output logic                          o_m_req_valid,
  output logic                          o_m_req_read,
  output logic [ADDR_WIDTH-1:0]         o_m_req_addr,
  output logic                          o_m_wdata_valid,
  output logic [DATA_WIDTH-1:0]         o_m_wdata,
  input  logic                          i_m_rddata_valid,
  input  logic [DATA_WIDTH-1:0]         i_m_rdata,
  input  logic                          i_m_busy,
  input  logic                          i_m_resp
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int CW = $clog2(BEATS + 1);
  localparam logic [CW-1:0] BEATS_C = CW'(BEATS);

  arb_state_t state, state_nxt;

  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         gnt_idx;
  logic [IW-1:0]         pick_idx;
  logic [NUM_REQ-1:0]    pick_gnt;
  logic                  pick_any;
  logic                  lat_read;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [CW-1:0]         beat_cnt, cnt_nxt;
  logic                  err;
  logic                  busy_q;
  logic                  busy_seen;
  logic                  exit_act;

  logic [ADDR_WIDTH-1:0] rq_addr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] rq_wdata [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign rq_addr[g]  = i_rq_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign rq_wdata[g] = i_rq_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .req (i_rq_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign pick_any = |pick_gnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    o_rq_gnt         = '0;
    o_rq_rdata_valid = '0;
    o_rq_rdata       = '0;
    o_rq_done        = '0;
    o_rq_err         = 1'b0;
    o_m_req_valid    = 1'b0;
    o_m_req_read     = 1'b0;
    o_m_req_addr     = '0;
    o_m_wdata_valid  = 1'b0;
    o_m_wdata        = '0;
    cnt_nxt          = beat_cnt;
    exit_act         = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_any) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        o_rq_gnt[gnt_idx] = 1'b1;
        o_m_req_valid     = 1'b1;
        o_m_req_read      = lat_read;
        o_m_req_addr      = lat_addr;
        state_nxt         = S_ACTIVE;
      end
      S_ACTIVE: begin
        o_rq_gnt[gnt_idx] = 1'b1;
        o_rq_rdata        = i_m_rdata;
        // Strobes beyond BEATS are swallowed so the master never sees an overlong burst.
        if (!lat_read && i_rq_wdata_valid[gnt_idx] && (beat_cnt < BEATS_C)) begin
          o_m_wdata_valid = 1'b1;
          o_m_wdata       = rq_wdata[gnt_idx];
          cnt_nxt         = beat_cnt + CW'(1);
        end
        if (lat_read && i_m_rddata_valid) begin
          o_rq_rdata_valid[gnt_idx] = 1'b1;
          if (beat_cnt < BEATS_C) cnt_nxt = beat_cnt + CW'(1);
        end
        if (busy_seen && busy_q && !i_m_busy) begin
          exit_act  = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_rq_gnt[gnt_idx]  = 1'b1;
        o_rq_done[gnt_idx] = 1'b1;
        o_rq_err           = err;
        state_nxt          = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Outputs are held quiet for the whole reset cycle, not just after the edge.
    if (i_reset) begin
      state_nxt        = S_IDLE;
      o_rq_gnt         = '0;
      o_rq_rdata_valid = '0;
      o_rq_rdata       = '0;
      o_rq_done        = '0;
      o_rq_err         = 1'b0;
      o_m_req_valid    = 1'b0;
      o_m_req_read     = 1'b0;
      o_m_req_addr     = '0;
      o_m_wdata_valid  = 1'b0;
      o_m_wdata        = '0;
      cnt_nxt          = '0;
      exit_act         = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      lat_read  <= 1'b0;
      lat_addr  <= '0;
      beat_cnt  <= '0;
      err       <= 1'b0;
      busy_q    <= 1'b0;
      busy_seen <= 1'b0;
    end else begin
      busy_q <= i_m_busy;
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            gnt_idx  <= pick_idx;
            lat_read <= i_rq_read[pick_idx];
            lat_addr <= rq_addr[pick_idx];
          end
        end
        S_ISSUE: begin
          beat_cnt  <= '0;
          err       <= 1'b0;
          busy_seen <= 1'b0;
        end
        S_ACTIVE: begin
          beat_cnt <= cnt_nxt;
          if (i_m_busy) busy_seen <= 1'b1;
          if (i_m_resp || (exit_act && (cnt_nxt != BEATS_C))) err <= 1'b1;
        end
        S_DONE: begin
          if (int'(gnt_idx) == NUM_REQ - 1) rr_ptr <= '0;
          else                              rr_ptr <= gnt_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
